// File: rtl/if_fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// if_fetch_ctrl_if
// SRAM-like instruction-port bundle between the fetch sequencer (master) and
// the instruction memory (slave). There is at most one outstanding request.
//
// Signals:
//   inst_req      master->slave  request valid
//   inst_addr     master->slave  request address (valid while inst_req=1)
//   inst_addr_ok  slave->master  request accepted this cycle
//   inst_rdata    slave->master  read data, valid with inst_data_ok
//   inst_data_ok  slave->master  read data returned this cycle
// -----------------------------------------------------------------------------
interface if_fetch_ctrl_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_rdata,
    input  inst_data_ok
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_rdata,
    output inst_data_ok
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// if_fetch_ctrl
// Instruction-fetch sequencer between the PC and the SRAM-like instruction
// port. Issues one fetch at a time, tracks it through addr_ok/data_ok, and
// holds the returned instruction until ID accepts it. Branch/exception
// redirects restart fetching at a new PC and may cancel an in-flight fetch,
// in which case the returned data is silently discarded.
//
// Ports:
//   clk               clock
//   rst               synchronous, active-high reset (priority over all inputs)
//   id_stall_i        ID cannot accept an instruction this cycle
//   redirect_valid_i  one-cycle pulse: restart fetching at redirect_pc_i
//   redirect_pc_i     redirect target
//   inst_bus          SRAM-like instruction port (master side)
//   if_valid_o        if_inst_o/if_pc_o hold a valid fetched instruction
//   if_inst_o         fetched instruction (NOP_INST when if_valid_o=0)
//   if_pc_o           PC of if_inst_o (RESET_PC when if_valid_o=0)
//   busy_o            a request is outstanding (WAIT or DROP)
//
// Throughput is at best one instruction per three cycles (REQ, WAIT, HOLD);
// there is no prefetch.
// -----------------------------------------------------------------------------
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000,
  parameter logic [31:0] NOP_INST = 32'h00000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_stall_i,
  input  logic                   redirect_valid_i,
  input  logic [31:0]            redirect_pc_i,
  if_fetch_ctrl_if.master        inst_bus,
  output logic                   if_valid_o,
  output logic [31:0]            if_inst_o,
  output logic [31:0]            if_pc_o,
  output logic                   busy_o
);

  // REQ  : presenting a request at pc_q, waiting for addr_ok
  // WAIT : request accepted, waiting for data_ok; data will be presented
  // DROP : request accepted but cancelled by a redirect; data is discarded
  // HOLD : presenting a valid instruction to ID until it is consumed
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e      state_q,    state_d;
  logic [31:0] pc_q,       pc_d;       // address of the next fetch
  logic [31:0] req_pc_q,   req_pc_d;   // address of the outstanding fetch
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_inst_q,  if_inst_d;
  logic [31:0] if_pc_q,    if_pc_d;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before this edge regardless of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      if_valid_q <= 1'b0;
      if_inst_q  <= NOP_INST;
      if_pc_q    <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      if_valid_q <= if_valid_d;
      if_inst_q  <= if_inst_d;
      if_pc_q    <= if_pc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a hold-value default first, so no
  // path through the case statement can infer a latch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    if_valid_d = if_valid_q;
    if_inst_d  = if_inst_q;
    if_pc_d    = if_pc_q;

    unique case (state_q)
      S_REQ: begin
        if (redirect_valid_i) begin
          pc_d = redirect_pc_i;
          // An accepted request here belongs to the old pc: its data must be
          // swallowed before the redirected fetch can be issued.
          if (inst_bus.inst_addr_ok) begin
            state_d = S_DROP;
          end
        end else if (inst_bus.inst_addr_ok) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;  // wraps modulo 2^32
          state_d  = S_WAIT;
        end
      end

      S_WAIT: begin
        if (redirect_valid_i) begin
          pc_d = redirect_pc_i;
          // Data arriving with the redirect is dropped on the spot; otherwise
          // it is still in flight and must be drained in DROP.
          state_d = inst_bus.inst_data_ok ? S_REQ : S_DROP;
        end else if (inst_bus.inst_data_ok) begin
          if_valid_d = 1'b1;
          if_inst_d  = inst_bus.inst_rdata;
          if_pc_d    = req_pc_q;
          state_d    = S_HOLD;
        end
      end

      S_DROP: begin
        // Later redirects simply overwrite the restart address.
        if (redirect_valid_i) begin
          pc_d = redirect_pc_i;
        end
        if (inst_bus.inst_data_ok) begin
          state_d = S_REQ;
        end
      end

      S_HOLD: begin
        // A redirect kills the held instruction even while ID is stalled.
        if (redirect_valid_i || !id_stall_i) begin
          if_valid_d = 1'b0;
          if_inst_d  = NOP_INST;
          if_pc_d    = RESET_PC;
          state_d    = S_REQ;
        end
        if (redirect_valid_i) begin
          pc_d = redirect_pc_i;
        end
      end

      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The request is masked during the reset cycle itself, so the slave never
  // sees a request until the cycle after rst deasserts.
  assign inst_bus.inst_req  = (state_q == S_REQ) && !rst;
  assign inst_bus.inst_addr = pc_q;

  assign busy_o     = (state_q == S_WAIT) || (state_q == S_DROP);
  assign if_valid_o = if_valid_q;
  assign if_inst_o  = if_inst_q;
  assign if_pc_o    = if_pc_q;

endmodule
